audio_receiver: RTL and testbench
=================================

# audio_receiver

AC97 serial-input deserializer, the receive counterpart of the audio controller's output path. It runs in the `BIT_CLK` domain, frames `SDATA_IN` using the `SYNC` strobe the controller already drives, and decodes the tag, status and PCM slots. It presents the register-read status word and stereo capture samples to the CPU side through hold-until-acknowledged handshakes.

## Interface
- No parameters. AC97 frame geometry is fixed; constants live in the shared package.
- `BIT_CLK` in 1: AC97 bit clock, 12.288 MHz. Sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `SYNC` in 1: frame sync, as driven to the codec.
- `SDATA_IN` in 1: serial data from the codec.
- `codec_ready` out 1: tag bit 15 of the last good frame.
- `status_addr` out 7: register index from slot 1.
- `status_data` out 16: register data from slot 2.
- `status_valid` out 1: status word held; cleared by `status_ack`.
- `status_ack` in 1: consume the status word.
- `pcm_left` out 16: slot 3 sample, bits [19:4].
- `pcm_right` out 16: slot 4 sample, bits [19:4].
- `pcm_valid` out 1: sample pair held; cleared by `pcm_ack`.
- `pcm_ack` in 1: consume the sample pair.
- `pcm_ovf` out 1: sticky; a new pair arrived while `pcm_valid` was still set. Cleared only by reset.
- `sync_err` out 1: one-cycle pulse on a framing violation.

## Operation
- All sampling is on the rising edge of `BIT_CLK`. `SYNC` is registered into `sync_q` for edge detection.
- **Frame start:** the first cycle with `SYNC=1` and `sync_q=0`. The sample taken in that cycle is bit 0; the following samples are bits 1..255, tracked by an 8-bit `bit_cnt`. Bits are MSB-first within each slot.
- **State `HUNT`:** ignore `SDATA_IN`. On a frame start, load `bit_cnt=0` and go to `RECV`.
- **State `RECV`:**
  - `SYNC` must be 1 for bits 0..15 and 0 for bits 16..255.
  - Any violation, or bit 255 not followed by a frame start on the next cycle: pulse `sync_err`, discard the partial frame, go to `HUNT`.
  - If the violating cycle is itself a frame start, re-enter `RECV` with `bit_cnt=0` instead of going to `HUNT`.
  - `bit_cnt` wraps 255→0 on a legal restart.
- **Slot map** (bit ranges inclusive):
  - Tag: bits 0..15. Tag[15] = ready, tag[14] = slot 1 valid, tag[13] = slot 2 valid, tag[12] = slot 3 valid, tag[11] = slot 4 valid.
  - Slot 1: bits 16..35. Address = slot bits [18:12].
  - Slot 2: bits 36..55. Data = slot bits [19:4].
  - Slot 3: bits 56..75. Left = slot bits [19:4].
  - Slot 4: bits 76..95. Right = slot bits [19:4].
  - Bits 96..255 are ignored.
- **Commit:** in the cycle bit 95 is sampled, the frame is good so far.
  - `codec_ready` is updated from tag[15].
  - If tag[14] and tag[13] are both set, load `status_addr`/`status_data` and set `status_valid`. This overwrites an unacked word.
  - If tag[12] and tag[11] are both set, load `pcm_left`/`pcm_right` and set `pcm_valid`. If `pcm_valid` was already 1 and `pcm_ack` is not asserted in that cycle, also set `pcm_ovf`.
  - A framing error after bit 95 does not revoke a commit that already happened.
- **Acknowledge:** `*_ack` clears its valid bit the next cycle. A commit in the same cycle as an ack wins: valid stays 1 and the data is new, with no overflow.

## Timing
- **Reset values:** all outputs 0, state `HUNT`, `bit_cnt` 0, `sync_q` 0.
- Reset mid-frame aborts the frame. The block then requires a fresh `SYNC` rising edge.
- **Latency:** outputs change on the clock edge after bit 95 is sampled, i.e. 96 cycles after the frame-start edge.
- `sync_err` asserts on the clock edge after the offending sample and lasts exactly one cycle.
- The first frame after reset or `HUNT` is decoded if it is well formed; no warm-up frame is needed.
- `status_*` and `pcm_*` data are stable while the matching valid bit is 1, except for the documented overwrite.

## Structure
- Package `audio_pkg`:
  - `FRAME_BITS=256`, `SYNC_BITS=16`.
  - Slot start indices 16/36/56/76, `COMMIT_BIT=95`.
  - Tag bit positions.
  - State enum {`HUNT`, `RECV`}.
- One 20-bit slot shift register plus the tag register, latched at slot boundaries.
- No sub-module required. The control FSM and datapath together are roughly 150–200 lines.

## Test plan
- **Reset:** reset asserted mid-stream → all outputs 0; the next well-formed frame decodes.
- **Full frame:** tag `0xF800`, slot 1 address `0x26`, slot 2 `0x000F`, slot 3 `0x1234`, slot 4 `0xABCD` → 96 cycles after the frame start:
  - `codec_ready=1`, `status_addr=0x26`, `status_data=0x000F`, `status_valid=1`;
  - `pcm_left=0x1234`, `pcm_right=0xABCD`, `pcm_valid=1`;
  - `sync_err` never asserts.
- **Missing slot 4:** tag `0xF000` → status committed; `pcm_valid` stays 0 and PCM outputs are unchanged.
- **Overflow:** two good PCM frames with no `pcm_ack` → second pair visible and `pcm_ovf=1`. A third frame with `pcm_ack` in its commit cycle → `pcm_ovf` stays 1, `pcm_valid` stays 1.
- **Short SYNC:** `SYNC` high for only 8 bits → `sync_err` pulses at bit 8, no valid asserted; the next good frame decodes.
- **Late or early restart:**
  - A frame start at bit 200 → `sync_err` pulses, then the frame restarting there decodes normally.
  - No `SYNC` after bit 255 → `sync_err` pulses and the block enters `HUNT`.

Source files
------------

// File: rtl/audio_receiver_pkg.sv
// audio_pkg: AC97 receive frame geometry, tag layout and FSM states
package audio_pkg;

   typedef logic [7:0] bit_idx_t;

   localparam int FRAME_BITS = 256;
   localparam int SYNC_BITS  = 16;
   localparam int SLOT_BITS  = 20;

   localparam bit_idx_t SLOT1_START = 8'd16;
   localparam bit_idx_t SLOT2_START = 8'd36;
   localparam bit_idx_t SLOT3_START = 8'd56;
   localparam bit_idx_t SLOT4_START = 8'd76;
   localparam bit_idx_t COMMIT_BIT  = 8'd95;
   localparam bit_idx_t LAST_BIT    = bit_idx_t'(FRAME_BITS - 1);
   localparam bit_idx_t TAG_LAST    = bit_idx_t'(SYNC_BITS - 1);

   localparam int TAG_READY = 15;
   localparam int TAG_SLOT1 = 14;
   localparam int TAG_SLOT2 = 13;
   localparam int TAG_SLOT3 = 12;
   localparam int TAG_SLOT4 = 11;

   typedef enum logic {HUNT, RECV} state_e;

   // index of the final bit of the slot starting at 'start'
   function automatic bit_idx_t slot_last(input bit_idx_t start);
      return start + bit_idx_t'(SLOT_BITS - 1);
   endfunction

endpackage

// File: rtl/audio_receiver_if.sv
// audio_receiver_if: serial link from the codec plus CPU-side status/PCM handshakes
interface audio_receiver_if;
   logic        SYNC;
   logic        SDATA_IN;
   logic        codec_ready;
   logic [6:0]  status_addr;
   logic [15:0] status_data;
   logic        status_valid;
   logic        status_ack;
   logic [15:0] pcm_left;
   logic [15:0] pcm_right;
   logic        pcm_valid;
   logic        pcm_ack;
   logic        pcm_ovf;
   logic        sync_err;

   modport master (
      input  SYNC, SDATA_IN, status_ack, pcm_ack,
      output codec_ready, status_addr, status_data, status_valid,
             pcm_left, pcm_right, pcm_valid, pcm_ovf, sync_err
   );

   modport slave (
      output SYNC, SDATA_IN, status_ack, pcm_ack,
      input  codec_ready, status_addr, status_data, status_valid,
             pcm_left, pcm_right, pcm_valid, pcm_ovf, sync_err
   );
endinterface

// File: rtl/audio_receiver.sv
// audio_receiver: AC97 SDATA_IN deserializer decoding tag, status and PCM slots
module audio_receiver (
   input logic              BIT_CLK,
   input logic              rst_n,
   audio_receiver_if.master bus
);
   import audio_pkg::*;

   state_e      state_q, state_d;
   logic        sync_q;
   bit_idx_t    bit_cnt_q, bit_cnt_d;
   logic [15:0] tag_q, tag_d;
   logic [18:0] slot_q, slot_d;
   logic [6:0]  addr_q, addr_d;
   logic [15:0] sdat_q, sdat_d;
   logic [15:0] left_q, left_d;
   logic        ready_q, ready_d;
   logic [6:0]  st_addr_q, st_addr_d;
   logic [15:0] st_data_q, st_data_d;
   logic        st_valid_q, st_valid_d;
   logic [15:0] pcm_l_q, pcm_l_d;
   logic [15:0] pcm_r_q, pcm_r_d;
   logic        pcm_valid_q, pcm_valid_d;
   logic        ovf_q, ovf_d;
   logic        err_q;
   logic        frame_start, active, err, commit, st_commit, pcm_commit;

   assign frame_start = bus.SYNC & ~sync_q;

   // framing FSM: bit_cnt_d is the index of the sample taken this cycle when active
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      active    = 1'b0;
      err       = 1'b0;
      if (state_q == HUNT) begin
         if (frame_start) begin
            state_d   = RECV;
            bit_cnt_d = '0;
            active    = 1'b1;
         end
      end else begin
         err       = (bit_cnt_q == LAST_BIT) ? ~frame_start :
                     (bit_cnt_q < TAG_LAST)  ? ~bus.SYNC   : bus.SYNC;
         active    = ~err | frame_start;
         state_d   = active ? RECV : HUNT;
         bit_cnt_d = err ? '0 : bit_cnt_q + 8'd1;
      end
   end

   // slot datapath: the shift register holds the first 19 bits of a slot, the 20th arrives live
   always_comb begin
      tag_d  = (active && bit_cnt_d <= TAG_LAST) ? {tag_q[14:0], bus.SDATA_IN} : tag_q;
      slot_d = active ? {slot_q[17:0], bus.SDATA_IN} : slot_q;
      addr_d = (active && bit_cnt_d == slot_last(SLOT1_START)) ? slot_q[17:11] : addr_q;
      sdat_d = (active && bit_cnt_d == slot_last(SLOT2_START)) ? slot_q[18:3]  : sdat_q;
      left_d = (active && bit_cnt_d == slot_last(SLOT3_START)) ? slot_q[18:3]  : left_q;
   end

   // commit at bit 95; a commit beats a same-cycle acknowledge
   always_comb begin
      commit      = active && bit_cnt_d == COMMIT_BIT;
      st_commit   = commit & tag_q[TAG_SLOT1] & tag_q[TAG_SLOT2];
      pcm_commit  = commit & tag_q[TAG_SLOT3] & tag_q[TAG_SLOT4];
      ready_d     = commit ? tag_q[TAG_READY] : ready_q;
      st_addr_d   = st_commit ? addr_q : st_addr_q;
      st_data_d   = st_commit ? sdat_q : st_data_q;
      st_valid_d  = st_commit | (st_valid_q & ~bus.status_ack);
      pcm_l_d     = pcm_commit ? left_q : pcm_l_q;
      pcm_r_d     = pcm_commit ? slot_q[18:3] : pcm_r_q;
      pcm_valid_d = pcm_commit | (pcm_valid_q & ~bus.pcm_ack);
      ovf_d       = ovf_q | (pcm_commit & pcm_valid_q & ~bus.pcm_ack);
   end

   // state and output registers
   always_ff @(posedge BIT_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         sync_q      <= 1'b0;
         bit_cnt_q   <= '0;
         tag_q       <= '0;
         slot_q      <= '0;
         addr_q      <= '0;
         sdat_q      <= '0;
         left_q      <= '0;
         ready_q     <= 1'b0;
         st_addr_q   <= '0;
         st_data_q   <= '0;
         st_valid_q  <= 1'b0;
         pcm_l_q     <= '0;
         pcm_r_q     <= '0;
         pcm_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= bus.SYNC;
         bit_cnt_q   <= bit_cnt_d;
         tag_q       <= tag_d;
         slot_q      <= slot_d;
         addr_q      <= addr_d;
         sdat_q      <= sdat_d;
         left_q      <= left_d;
         ready_q     <= ready_d;
         st_addr_q   <= st_addr_d;
         st_data_q   <= st_data_d;
         st_valid_q  <= st_valid_d;
         pcm_l_q     <= pcm_l_d;
         pcm_r_q     <= pcm_r_d;
         pcm_valid_q <= pcm_valid_d;
         ovf_q       <= ovf_d;
         err_q       <= err;
      end
   end

   assign bus.codec_ready  = ready_q;
   assign bus.status_addr  = st_addr_q;
   assign bus.status_data  = st_data_q;
   assign bus.status_valid = st_valid_q;
   assign bus.pcm_left     = pcm_l_q;
   assign bus.pcm_right    = pcm_r_q;
   assign bus.pcm_valid    = pcm_valid_q;
   assign bus.pcm_ovf      = ovf_q;
   assign bus.sync_err     = err_q;

endmodule

// File: tb/tb_audio_receiver.sv
// tb_audio_receiver: table vectors, framing corner cases and randomized frames vs a reference model
module tb_audio_receiver;

   logic BIT_CLK = 1'b0;
   logic rst_n;

   audio_receiver_if bus();

   audio_receiver dut (.BIT_CLK(BIT_CLK), .rst_n(rst_n), .bus(bus));

   always #5 BIT_CLK = ~BIT_CLK;

   int total = 0, bad = 0, errs = 0, last_err = -1, gidx = 0, fb;
   logic sy [512];
   logic sd [512];
   logic pa [512];
   logic sa [512];

   typedef struct {
      logic [15:0] tag;
      logic [6:0]  a;
      logic [15:0] d, l, r;
      int          pp, sp;
      logic        e_rdy;
      logic [6:0]  e_a;
      logic [15:0] e_d;
      logic        e_sv;
      logic [15:0] e_l, e_r;
      logic        e_pv, e_ov;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic chk_all(input string n, input logic r, input logic [6:0] a, input logic [15:0] d,
                          input logic v, input logic [15:0] l, input logic [15:0] rr,
                          input logic pv, input logic ov);
      chk({n, ".ready"}, 32'(bus.codec_ready), 32'(r));
      chk({n, ".saddr"}, 32'(bus.status_addr), 32'(a));
      chk({n, ".sdata"}, 32'(bus.status_data), 32'(d));
      chk({n, ".svalid"}, 32'(bus.status_valid), 32'(v));
      chk({n, ".left"}, 32'(bus.pcm_left), 32'(l));
      chk({n, ".right"}, 32'(bus.pcm_right), 32'(rr));
      chk({n, ".pvalid"}, 32'(bus.pcm_valid), 32'(pv));
      chk({n, ".ovf"}, 32'(bus.pcm_ovf), 32'(ov));
   endtask

   // build one 256-bit frame from field values; junk fills the don't-care bits
   task automatic fill(input logic [15:0] tag, input logic [6:0] a, input logic [15:0] d,
                       input logic [15:0] l, input logic [15:0] r, input int sync_len,
                       input int pp, input int sp);
      logic [19:0]  s1, s2, s3, s4;
      logic [255:0] f;
      s1 = {1'($urandom), a, 12'($urandom)};
      s2 = {d, 4'($urandom)};
      s3 = {l, 4'($urandom)};
      s4 = {r, 4'($urandom)};
      f  = {tag, s1, s2, s3, s4, 160'd0};
      for (int i = 0; i < 256; i++) begin
         sy[i] = (i < sync_len);
         sd[i] = (i < 96) ? f[255 - i] : 1'($urandom);
         pa[i] = (i == pp);
         sa[i] = (i == sp);
      end
   endtask

   task automatic play(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge BIT_CLK);
         if (bus.sync_err) begin
            errs++;
            last_err = gidx - 1;
         end
         bus.SYNC       = sy[i];
         bus.SDATA_IN   = sd[i];
         bus.pcm_ack    = pa[i];
         bus.status_ack = sa[i];
         gidx++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         sy[i] = 1'b0; sd[i] = 1'b0; pa[i] = 1'b0; sa[i] = 1'b0;
      end
      play(0, n);
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      bus.SYNC = 1'b0; bus.SDATA_IN = 1'b0; bus.pcm_ack = 1'b0; bus.status_ack = 1'b0;
      #1;
   endtask

   function automatic int pick();
      int r = int'($urandom_range(0, 4));
      return r == 0 ? -1 : r == 1 ? 95 : int'($urandom_range(0, 250));
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        m_rdy, m_sv, m_pv, m_ov, sv_pre, pv_pre;
      logic [6:0]  m_a, a;
      logic [15:0] m_d, m_l, m_r, tag, d, l, r;
      int          pp, sp;

      tbl[0] = '{16'hF800, 7'h26, 16'h000F, 16'h1234, 16'hABCD, -1, -1,
                 1'b1, 7'h26, 16'h000F, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b0};
      tbl[1] = '{16'hF000, 7'h11, 16'h2222, 16'h5555, 16'h6666, 10, -1,
                 1'b1, 7'h11, 16'h2222, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0};
      tbl[2] = '{16'h9800, 7'h33, 16'h4444, 16'h0101, 16'h0202, -1, 20,
                 1'b1, 7'h11, 16'h2222, 1'b0, 16'h0101, 16'h0202, 1'b1, 1'b0};
      tbl[3] = '{16'h1800, 7'h44, 16'h5555, 16'h0303, 16'h0404, -1, -1,
                 1'b0, 7'h11, 16'h2222, 1'b0, 16'h0303, 16'h0404, 1'b1, 1'b1};
      tbl[4] = '{16'h9800, 7'h45, 16'h5656, 16'h0505, 16'h0606, 95, -1,
                 1'b1, 7'h11, 16'h2222, 1'b0, 16'h0505, 16'h0606, 1'b1, 1'b1};
      tbl[5] = '{16'hD800, 7'h55, 16'h6666, 16'h0707, 16'h0808, 150, -1,
                 1'b1, 7'h11, 16'h2222, 1'b0, 16'h0707, 16'h0808, 1'b0, 1'b1};

      rst_n = 1'b1;
      bus.SYNC = 1'b0; bus.SDATA_IN = 1'b0; bus.pcm_ack = 1'b0; bus.status_ack = 1'b0;
      #2;
      hold_reset();
      #10;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset.err", 32'(bus.sync_err), 0);
      @(negedge BIT_CLK);
      rst_n = 1'b1;
      idle(4);

      for (int k = 0; k < 6; k++) begin
         fill(tbl[k].tag, tbl[k].a, tbl[k].d, tbl[k].l, tbl[k].r, 16, tbl[k].pp, tbl[k].sp);
         play(0, 256);
         chk_all($sformatf("vec%0d", k), tbl[k].e_rdy, tbl[k].e_a, tbl[k].e_d, tbl[k].e_sv,
                 tbl[k].e_l, tbl[k].e_r, tbl[k].e_pv, tbl[k].e_ov);
      end
      chk("vec.errs", 32'(errs), 0);

      // reset mid-frame, then latency of the next frame's commit
      fill(16'hF800, 7'h26, 16'h000F, 16'h1234, 16'hABCD, 16, -1, -1);
      play(0, 40);
      hold_reset();
      chk_all("midreset", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge BIT_CLK);
      rst_n = 1'b1;
      idle(3);
      fill(16'hF800, 7'h26, 16'h000F, 16'h1234, 16'hABCD, 16, 200, 200);
      play(0, 96);
      chk("lat_pre.pvalid", 32'(bus.pcm_valid), 0);
      chk("lat_pre.svalid", 32'(bus.status_valid), 0);
      @(posedge BIT_CLK);
      #1;
      chk("lat_post.pvalid", 32'(bus.pcm_valid), 1);
      chk("lat_post.svalid", 32'(bus.status_valid), 1);
      chk("lat_post.ready", 32'(bus.codec_ready), 1);
      play(96, 256);
      chk_all("acked", 1, 7'h26, 16'h000F, 0, 16'h1234, 16'hABCD, 0, 0);

      // SYNC high for only 8 bits
      errs = 0;
      fb = gidx;
      fill(16'hF800, 7'h7F, 16'hFFFF, 16'h1111, 16'h2222, 8, -1, -1);
      play(0, 256);
      chk("short.errs", 32'(errs), 1);
      chk("short.pos", 32'(last_err), 32'(fb + 8));
      chk_all("short", 1, 7'h26, 16'h000F, 0, 16'h1234, 16'hABCD, 0, 0);
      fill(16'hF800, 7'h01, 16'h0202, 16'h0303, 16'h0404, 16, -1, -1);
      play(0, 256);
      chk_all("post_short", 1, 7'h01, 16'h0202, 1, 16'h0303, 16'h0404, 1, 0);
      chk("post_short.errs", 32'(errs), 1);

      // early frame start at bit 200
      errs = 0;
      fb = gidx;
      fill(16'hF800, 7'h0A, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16, 50, 50);
      play(0, 200);
      chk_all("restart_a", 1, 7'h0A, 16'h0A0A, 1, 16'h0B0B, 16'h0C0C, 1, 0);
      fill(16'hF800, 7'h0D, 16'h0D0D, 16'h0E0E, 16'h0F0F, 16, 60, 60);
      play(0, 256);
      chk("restart.errs", 32'(errs), 1);
      chk("restart.pos", 32'(last_err), 32'(fb + 200));
      chk_all("restart_b", 1, 7'h0D, 16'h0D0D, 1, 16'h0E0E, 16'h0F0F, 1, 0);

      // no frame start after bit 255
      errs = 0;
      fb = gidx;
      idle(5);
      chk("nosync.errs", 32'(errs), 1);
      chk("nosync.pos", 32'(last_err), 32'(fb));
      fill(16'hF800, 7'h12, 16'h1313, 16'h1414, 16'h1515, 16, 10, 10);
      play(0, 256);
      chk_all("hunt_c", 1, 7'h12, 16'h1313, 1, 16'h1414, 16'h1515, 1, 0);
      chk("hunt_c.errs", 32'(errs), 1);

      // randomized back-to-back frames against the reference model
      hold_reset();
      @(negedge BIT_CLK);
      rst_n = 1'b1;
      idle(2);
      errs = 0;
      m_rdy = 0; m_sv = 0; m_pv = 0; m_ov = 0; m_a = 0; m_d = 0; m_l = 0; m_r = 0;
      for (int k = 0; k < 40; k++) begin
         tag = 16'($urandom); a = 7'($urandom); d = 16'($urandom);
         l = 16'($urandom); r = 16'($urandom);
         pp = pick(); sp = pick();
         fill(tag, a, d, l, r, 16, pp, sp);
         play(0, 256);
         m_rdy  = tag[15];
         sv_pre = m_sv && !(sp >= 0 && sp < 95);
         if (tag[14] && tag[13]) begin
            m_a = a; m_d = d; m_sv = !(sp > 95);
         end else m_sv = sv_pre && !(sp >= 95);
         pv_pre = m_pv && !(pp >= 0 && pp < 95);
         if (tag[12] && tag[11]) begin
            m_ov = m_ov | (pv_pre && pp != 95);
            m_l = l; m_r = r; m_pv = !(pp > 95);
         end else m_pv = pv_pre && !(pp >= 95);
         chk_all($sformatf("rnd%0d", k), m_rdy, m_a, m_d, m_sv, m_l, m_r, m_pv, m_ov);
      end
      chk("rnd.errs", 32'(errs), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
